sd_sector_uart_streamer: RTL and testbench

Read-back counterpart of the UART-to-SD write path. On a start pulse it requests SECTOR_COUNT consecutive sectors from the SD read controller, beginning at START_ADDR. Each sector's 16-bit words are captured into an on-chip buffer, then serialised high byte first into the SD UART transmitter. It sits between the SD controller's read port and SDUartTX, and lets the team dump logged data back to a PC.

---
 rtl/sd_stream_pkg.sv | 27 ++
 rtl/sd_sector_buffer.sv | 28 ++
 rtl/sd_sector_uart_streamer.sv | 211 +++++++++++++++++++++
 tb/tb_sd_sector_uart_streamer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_stream_pkg.sv
// Shared types and constants for the SD sector read-back streamer.
// Holds the FSM encoding and the byte-order helper used when serialising words.
package sd_stream_pkg;

    localparam int unsigned ADDR_W           = 32;
    localparam int unsigned SECTOR_WORDS_DEF = 256;
    localparam bit          HI_FIRST         = 1'b1;

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StWaitInit = 4'd1,
        StReq      = 4'd2,
        StFill     = 4'd3,
        StDrainRd  = 4'd4,
        StDrainHi  = 4'd5,
        StDrainLo  = 4'd6,
        StTxWait   = 4'd7,
        StNext     = 4'd8,
        StFin      = 4'd9
    } state_t;

    // first=1 selects the byte that goes out first for a word.
    function automatic logic [7:0] pick_byte(input logic [15:0] word, input logic first);
        return (first == HI_FIRST) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/sd_sector_buffer.sv
// One-sector word buffer: simple dual-port RAM, one write port and one
// registered read port with a single cycle of latency.
module sd_sector_buffer #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array or read register so the RAM maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sd_sector_uart_streamer.sv
// Reads SECTOR_COUNT sectors from the SD read controller into a sector buffer
// and serialises each buffered word, high byte first, into the SD UART transmitter.
module sd_sector_uart_streamer
    import sd_stream_pkg::*;
#(
    parameter logic [ADDR_W-1:0] START_ADDR   = 32'h0,
    parameter int unsigned       SECTOR_WORDS = SECTOR_WORDS_DEF,
    parameter int unsigned       SECTOR_COUNT = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic              init_end,
    input  logic              rd_busy,
    input  logic              rd_data_en,
    input  logic [15:0]       rd_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              tx_ready,
    output logic              tx_flag,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned        WORD_AW     = $clog2(SECTOR_WORDS);
    localparam logic [WORD_AW-1:0] LAST_WORD   = WORD_AW'(SECTOR_WORDS - 1);
    localparam logic [16:0]        LAST_SECTOR = 17'(SECTOR_COUNT);

    state_t              state_q, state_d;
    logic [WORD_AW-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]         sector_cnt_q, sector_cnt_d;
    logic                lo_phase_q, lo_phase_d;
    logic                seen_low_q, seen_low_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                tx_flag_q, tx_flag_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;

    logic                buf_we;
    logic                buf_re;
    logic [15:0]         buf_word;

    sd_sector_buffer #(
        .DEPTH (SECTOR_WORDS),
        .WIDTH (16)
    ) u_buffer (
        .clk   (sys_clk),
        .we    (buf_we),
        .waddr (word_cnt_q),
        .wdata (rd_data),
        .re    (buf_re),
        .raddr (word_cnt_q),
        .rdata (buf_word)
    );

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        sector_cnt_d = sector_cnt_q;
        lo_phase_d   = lo_phase_q;
        seen_low_d   = seen_low_q;
        rd_en_d      = 1'b0;
        rd_addr_d    = rd_addr_q;
        tx_flag_d    = 1'b0;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        buf_we       = 1'b0;
        buf_re       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StWaitInit;
                    busy_d       = 1'b1;
                    overflow_d   = 1'b0;
                    rd_addr_d    = START_ADDR;
                    sector_cnt_d = '0;
                end
            end
            StWaitInit: begin
                if (init_end) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                // Re-checking init_end here also covers a card dropping out between sectors.
                if (init_end && !rd_busy) begin
                    rd_en_d    = 1'b1;
                    word_cnt_d = '0;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (rd_data_en) begin
                    buf_we = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = StDrainRd;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            StDrainRd: begin
                buf_re  = 1'b1;
                state_d = StDrainHi;
            end
            StDrainHi: begin
                if (tx_ready) begin
                    tx_data_d  = pick_byte(buf_word, 1'b1);
                    tx_flag_d  = 1'b1;
                    lo_phase_d = 1'b0;
                    seen_low_d = 1'b0;
                    state_d    = StTxWait;
                end
            end
            StDrainLo: begin
                if (tx_ready) begin
                    tx_data_d  = pick_byte(buf_word, 1'b0);
                    tx_flag_d  = 1'b1;
                    lo_phase_d = 1'b1;
                    seen_low_d = 1'b0;
                    state_d    = StTxWait;
                end
            end
            StTxWait: begin
                // A low-then-high on tx_ready marks the end of the frame just strobed.
                if (!tx_ready) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (!lo_phase_q) begin
                        state_d = StDrainLo;
                    end else if (word_cnt_q == LAST_WORD) begin
                        state_d = StNext;
                    end else begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = StDrainRd;
                    end
                end
            end
            StNext: begin
                rd_addr_d    = rd_addr_q + 32'd1;
                sector_cnt_d = sector_cnt_q + 16'd1;
                if (({1'b0, sector_cnt_q} + 17'd1) == LAST_SECTOR) begin
                    state_d = StFin;
                end else begin
                    state_d = StReq;
                end
            end
            StFin: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Words arriving outside a fill have nowhere to go.
        if (rd_data_en && (state_q != StFill)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            sector_cnt_q <= '0;
            lo_phase_q   <= 1'b0;
            seen_low_q   <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= START_ADDR;
            tx_flag_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            sector_cnt_q <= sector_cnt_d;
            lo_phase_q   <= lo_phase_d;
            seen_low_q   <= seen_low_d;
            rd_en_q      <= rd_en_d;
            rd_addr_q    <= rd_addr_d;
            tx_flag_q    <= tx_flag_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign tx_flag  = tx_flag_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_sd_sector_uart_streamer.sv
// Scoreboard bench: an SD read model pushes the expected byte stream as it hands
// out random words; a UART model pops and compares on every tx_flag strobe.
module tb_sd_sector_uart_streamer;

    localparam logic [31:0] START = 32'hFFFF_FFFE;
    localparam int          SW    = 256;
    localparam int          SC    = 3;
    localparam int          DUMP_BYTES = 2 * SW * SC;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start;
    logic        init_end;
    logic        rd_busy;
    logic        rd_data_en;
    logic [15:0] rd_data;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic        tx_ready;
    logic        tx_flag;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;
    logic        overflow;

    int vectors     = 0;
    int miscompares = 0;
    int rx_count    = 0;
    int done_count  = 0;
    int rd_en_count = 0;
    int slow_until  = 0;
    int stray_req   = 0;
    int stray_ack   = 0;

    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_addr[$];

    sd_sector_uart_streamer #(
        .START_ADDR   (START),
        .SECTOR_WORDS (SW),
        .SECTOR_COUNT (SC)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .init_end   (init_end),
        .rd_busy    (rd_busy),
        .rd_data_en (rd_data_en),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .tx_ready   (tx_ready),
        .tx_flag    (tx_flag),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rd_en"}, rd_en, 0);
        check({tag, " rd_addr"}, rd_addr, START);
        check({tag, " tx_flag"}, tx_flag, 0);
        check({tag, " tx_data"}, tx_data, 8'h00);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    task automatic push_addrs();
        for (int s = 0; s < SC; s++) begin
            exp_addr.push_back(START + 32'(s));
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (rx_count < target) begin
            note_fail("rx_timeout", $sformatf("got %0d bytes, expected at least %0d", rx_count, target));
        end
    endtask

    task automatic wait_done(input int base, input int budget);
        int n = 0;
        while (done_count == base && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (done_count == base) begin
            note_fail("done_timeout", $sformatf("no done within %0d cycles, expected a pulse", budget));
        end
    endtask

    // SD controller model: answers each rd_en with SW random words.
    initial begin : sd_model
        int          words_left;
        bit          active;
        logic [15:0] w;
        rd_data_en = 1'b0;
        rd_data    = 16'h0;
        active     = 1'b0;
        words_left = 0;
        forever begin
            @(negedge sys_clk);
            rd_data_en = 1'b0;
            if (sys_rst) begin
                active = 1'b0;
            end else if (rd_en) begin
                rd_en_count++;
                if (exp_addr.size() == 0) begin
                    note_fail("rd_en_unexpected", $sformatf("got rd_en at %h, expected none", rd_addr));
                end else begin
                    check("rd_addr", rd_addr, exp_addr.pop_front());
                end
                active     = 1'b1;
                words_left = SW;
            end else if (active) begin
                if ($urandom_range(0, 3) != 0) begin
                    w          = 16'($urandom);
                    rd_data    = w;
                    rd_data_en = 1'b1;
                    exp_bytes.push_back(w[15:8]);
                    exp_bytes.push_back(w[7:0]);
                    words_left--;
                    if (words_left == 0) active = 1'b0;
                end
            end else if (stray_ack != stray_req) begin
                rd_data    = 16'hDEAD;
                rd_data_en = 1'b1;
                stray_ack++;
            end
        end
    end

    // UART model and scoreboard monitor.
    initial begin : uart_model
        int         low_left;
        logic [7:0] eb;
        tx_ready = 1'b1;
        low_left = 0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                tx_ready = 1'b1;
                low_left = 0;
            end else if (tx_flag) begin
                if (!tx_ready) begin
                    note_fail("tx_flag_busy", "got strobe while UART busy, expected none");
                end
                if (exp_bytes.size() == 0) begin
                    note_fail("tx_unexpected", $sformatf("got byte %h, expected no byte", tx_data));
                end else begin
                    eb = exp_bytes.pop_front();
                    check("tx_data", tx_data, eb);
                end
                rx_count++;
                low_left = (rx_count <= slow_until) ? 5208 : int'($urandom_range(1, 3));
                tx_ready = 1'b0;
            end else if (low_left > 0) begin
                low_left--;
                if (low_left == 0) tx_ready = 1'b1;
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge sys_clk);
            if (!sys_rst && done) begin
                done_count++;
                check("bytes_pending_at_done", exp_bytes.size(), 0);
                check("addrs_pending_at_done", exp_addr.size(), 0);
            end
        end
    end

    initial begin : main
        int base_rx;
        int base_done;
        int base_rd;
        sys_rst    = 1'b1;
        start      = 1'b0;
        init_end   = 1'b0;
        rd_busy    = 1'b0;
        slow_until = 0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("por");
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        check("idle_busy", busy, 0);

        // Dump A: init/busy gating, mid-dump start, stray word during drain.
        base_rx   = rx_count;
        base_done = done_count;
        base_rd   = rd_en_count;
        push_addrs();
        pulse_start();
        check("busy_after_start_a", busy, 1);
        repeat (100) @(negedge sys_clk);
        check("no_rd_en_before_init", rd_en_count - base_rd, 0);
        init_end = 1'b1;
        rd_busy  = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("no_rd_en_while_rd_busy", rd_en_count - base_rd, 0);
        rd_busy = 1'b0;
        @(negedge sys_clk);
        check("rd_en_first_free_cycle", rd_en, 1);
        wait_rx(base_rx + 40, 20000);
        pulse_start();
        stray_req++;
        repeat (4) @(negedge sys_clk);
        check("overflow_set", overflow, 1);
        wait_done(base_done, 40000);
        repeat (10) @(negedge sys_clk);
        check("bytes_dump_a", rx_count - base_rx, DUMP_BYTES);
        check("done_pulses_a", done_count - base_done, 1);
        check("overflow_sticky", overflow, 1);
        check("busy_after_done_a", busy, 0);

        // Dump B: slow UART start, then reset partway into sector 3.
        base_rx    = rx_count;
        base_done  = done_count;
        push_addrs();
        slow_until = rx_count + 3;
        pulse_start();
        check("overflow_cleared_by_start", overflow, 0);
        check("busy_after_start_b", busy, 1);
        wait_rx(base_rx + 2, 20000);
        pulse_start();
        wait_rx(base_rx + 4 * SW + 301, 60000);
        #1 sys_rst = 1'b1;
        #1 check_reset_outputs("mid_dump_reset");
        check("no_done_b", done_count - base_done, 0);
        exp_bytes.delete();
        exp_addr.delete();
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Dump C: restart after reset must begin again at START.
        base_rx   = rx_count;
        base_done = done_count;
        push_addrs();
        pulse_start();
        check("busy_after_start_c", busy, 1);
        wait_done(base_done, 40000);
        repeat (10) @(negedge sys_clk);
        check("bytes_dump_c", rx_count - base_rx, DUMP_BYTES);
        check("done_pulses_c", done_count - base_done, 1);
        check("overflow_clean_c", overflow, 0);
        check("rd_addr_after_c", rd_addr, START + 32'(SC));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
